// File: rtl/alu_result_fifo.sv
// alu_result_fifo: first-word-fall-through FIFO holding ALU results
// ({op, overflow, zero, cout, result}) between the combinational ALU and a
// consumer that may stall. The head entry is shown combinationally on out_*.
// Optional build macro ALU_STICKY_OVF_EN adds a sticky arithmetic-overflow
// flag (sticky_ovf) with a synchronous clear input (sticky_clr).
module alu_result_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_result,
    input  logic                       in_cout,
    input  logic                       in_zero,
    input  logic                       in_overflow,
    input  logic [2:0]                 in_op,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_result,
    output logic                       out_cout,
    output logic                       out_zero,
    output logic                       out_overflow,
    output logic [2:0]                 out_op,
`ifdef ALU_STICKY_OVF_EN
    output logic                       sticky_ovf,
    input  logic                       sticky_clr,
`endif
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam int EW = WIDTH + 6;

    logic [EW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full, empty;
    logic          push, pop;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign count     = count_q;

    // A full FIFO refuses pushes even when a pop happens in the same cycle,
    // which keeps in_ready independent of out_ready.
    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // Head entry falls through combinationally; stale while empty.
    assign {out_op, out_overflow, out_zero, out_cout, out_result} = mem_q[rd_ptr_q];

    // Next-state for pointers and occupancy; pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage is data only and is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {in_op, in_overflow, in_zero, in_cout, in_result};
    end

    // Control state: async reset discards any entries in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

`ifdef ALU_STICKY_OVF_EN
    logic sticky_q, sticky_d;
    logic sticky_set;

    // Only ADD/SUB overflow is meaningful; logic ops and SLT never set it.
    assign sticky_set = push && in_overflow && (in_op == 3'b000 || in_op == 3'b001);
    assign sticky_ovf = sticky_q;

    // Set has priority over a same-cycle clear so no overflow is lost.
    always_comb begin
        sticky_d = sticky_q;
        if (sticky_set)      sticky_d = 1'b1;
        else if (sticky_clr) sticky_d = 1'b0;
    end

    // Sticky overflow register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sticky_q <= 1'b0;
        else        sticky_q <= sticky_d;
    end
`endif

endmodule

// File: doc/alu_result_fifo.md
Name: alu_result_fifo

Overview:
- Buffers results from the 32-bit ALU (out, cout, zero, overflow, plus the op that produced them) for downstream consumers such as writeback or bench scoreboards.
- Sits directly downstream of the ALU.
- Accepts one result per cycle over a valid/ready push port and presents results in order on a valid/ready pop port with first-word-fall-through timing.
- Decouples the combinational ALU from a stalling consumer.

Parameters:
- WIDTH, 32: result data width; must match the ALU output width.
- DEPTH, 4: number of entries; power of 2, minimum 2.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- in_valid  in  1  ALU result present this cycle.
- in_ready  out  1  FIFO can accept; equals !full.
- in_result  in  WIDTH  ALU out.
- in_cout  in  1  ALU carry out.
- in_zero  in  1  ALU zero flag.
- in_overflow  in  1  ALU overflow flag.
- in_op  in  3  ALU op code (000 ADD, 001 SUB, 010 XOR, 011 SLT, 100 AND, 101 NAND, 110 NOR, 111 OR).
- out_valid  out  1  head entry valid; equals !empty.
- out_ready  in  1  consumer takes head this cycle.
- out_result  out  WIDTH  head result.
- out_cout, out_zero, out_overflow  out  1 each  head flags.
- out_op  out  3  head op code.
- count  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.

Behaviour:
- Push: occurs when in_valid && in_ready. The entry {op, overflow, zero, cout, result} is written at wr_ptr, and wr_ptr increments modulo DEPTH.
- Pop: occurs when out_valid && out_ready. rd_ptr increments modulo DEPTH.
- Head outputs: out_* is driven combinationally from the entry at rd_ptr.
  - A pushed entry is visible on out_* the cycle after the push edge. Latency is 1 cycle when the FIFO is empty.
  - When empty, out_* shows stale storage. The consumer must qualify with out_valid.
- in_ready does not depend on out_ready. When full, a push is refused even if a pop occurs in the same cycle.
- Simultaneous push and pop when neither full nor empty: both pointers advance and count is unchanged.
- Simultaneous push and pop when empty: only the push occurs, because out_valid=0.
- Count:
  - Increments on push-only.
  - Decrements on pop-only.
  - Holds when both or neither occur.
  - Never exceeds DEPTH and never underflows.
- Pointers are $clog2(DEPTH) bits and wrap naturally. full = (count==DEPTH); empty = (count==0).
- Reset (rst_n low, any time including mid-transfer):
  - wr_ptr=0, rd_ptr=0, count=0.
  - out_valid=0, in_ready=1.
  - Storage contents are not reset; out_* data values are undefined while empty.
  - Entries in flight are discarded.
- Deassertion of rst_n is synchronised externally. The first push after reset is accepted on the first rising edge with rst_n high.
- in_* values presented while in_ready=0 are ignored. The producer must hold them until accepted.

Optional Feature:
- Macro: ALU_STICKY_OVF_EN.
- When defined:
  - Extra ports: sticky_ovf (out, 1) and sticky_clr (in, 1).
  - sticky_ovf sets on any accepted push with in_overflow=1 and in_op in {000, 001}.
  - It clears synchronously when sticky_clr=1. Set wins over clear in the same cycle.
  - It resets to 0 on rst_n low.
  - Overflow on logic ops or SLT never sets it.
- When not defined: the ports and register do not exist, and behaviour is otherwise identical.

Test Plan:
- Reset then idle: after rst_n 0→1 -> out_valid=0, in_ready=1, count=0.
- Single push of result=32'h00000001, op=010, zero=0, then out_ready=1 -> next cycle out_valid=1, out_result=32'h00000001, out_op=010; after the pop, count=0 and out_valid=0.
- Fill with DEPTH=4 pushes of 32'hA, 32'hB, 32'hC, 32'hD, out_ready=0 -> count=4, in_ready=0; a 5th push of 32'hE is ignored; draining yields A, B, C, D in order.
- Steady stream, push and pop every cycle for 10 cycles starting from count=1 -> count stays 1; outputs emerge in order with 1-cycle lag; pointers wrap past index 3 correctly.
- Full plus simultaneous pop: count=4, in_valid=1, out_ready=1 -> pop occurs, push refused, count=3; the refused value is accepted the next cycle.
- Reset mid-stream with count=3: assert rst_n=0 asynchronously between edges -> out_valid falls immediately and count=0. With ALU_STICKY_OVF_EN: push op=000, overflow=1 -> sticky_ovf=1; push op=010, overflow=1 from a clear state -> sticky_ovf stays 0; sticky_clr -> 0.
